// File: rtl/neander_mem_arbiter.sv
// Two-port arbiter in front of the single-port Neander memory.
// CPU (REM/RDM path) and debug/loader port share the memory with a bounded
// burst counter for fairness; dbg_lock hands the memory to the debug port.
// Read data is routed back one cycle after the grant to whoever issued it.
module neander_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    input  logic                  dbg_lock,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    typedef enum logic {OWN_CPU, OWN_DBG} owner_e;
    typedef enum logic [1:0] {PEND_NONE, PEND_CPU, PEND_DBG} pend_e;

    owner_e                owner_q, owner_d;
    pend_e                 pend_q, pend_d;
    logic [3:0]            burst_q, burst_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0] cpu_hold_q, dbg_hold_q;

    logic eff_cpu_req, owner_req, other_req, gnt_own, gnt_oth;

    // Arbitration state and held read data; reset also kills any in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_CPU;
            pend_q      <= PEND_NONE;
            burst_q     <= '0;
            last_addr_q <= '0;
            cpu_hold_q  <= '0;
            dbg_hold_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            pend_q      <= pend_d;
            burst_q     <= burst_d;
            last_addr_q <= last_addr_d;
            cpu_hold_q  <= cpu_rdata;
            dbg_hold_q  <= dbg_rdata;
        end
    end

    // Read return: the pending port sees live memory data, the other holds.
    always_comb begin
        cpu_rvalid = (pend_q == PEND_CPU);
        dbg_rvalid = (pend_q == PEND_DBG);
        cpu_rdata  = cpu_rvalid ? mem_data_out : cpu_hold_q;
        dbg_rdata  = dbg_rvalid ? mem_data_out : dbg_hold_q;
    end

    // Grant decision, memory drive and next arbitration state.
    always_comb begin
        // Grants are gated by reset so nothing is driven while it is held.
        eff_cpu_req = cpu_req & ~dbg_lock;
        owner_req   = (owner_q == OWN_CPU) ? eff_cpu_req : dbg_req;
        other_req   = (owner_q == OWN_CPU) ? dbg_req : eff_cpu_req;
        gnt_own     = reset & owner_req & (~other_req | (burst_q < BURST_MAX));
        gnt_oth     = reset & ~gnt_own & other_req;
        cpu_gnt     = (owner_q == OWN_CPU) ? gnt_own : gnt_oth;
        dbg_gnt     = (owner_q == OWN_DBG) ? gnt_own : gnt_oth;

        owner_d     = owner_q;
        burst_d     = '0;
        last_addr_d = last_addr_q;
        pend_d      = PEND_NONE;
        // Idle cycles keep the last address so data_out does not move.
        mem_we      = 1'b0;
        mem_addr    = last_addr_q;
        mem_data_in = '0;

        if (gnt_own) begin
            burst_d = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 4'd1;
        end else if (gnt_oth) begin
            owner_d = (owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
            burst_d = 4'd1;
        end

        if (cpu_gnt) begin
            mem_we      = cpu_we;
            mem_addr    = cpu_addr;
            mem_data_in = cpu_wdata;
            last_addr_d = cpu_addr;
            pend_d      = cpu_we ? PEND_NONE : PEND_CPU;
        end else if (dbg_gnt) begin
            mem_we      = dbg_we;
            mem_addr    = dbg_addr;
            mem_data_in = dbg_wdata;
            last_addr_d = dbg_addr;
            pend_d      = dbg_we ? PEND_NONE : PEND_DBG;
        end
    end

`ifndef SYNTHESIS
    // Grants are mutually exclusive.
    a_onehot: assert property (@(posedge clk) disable iff (!reset)
        !(cpu_gnt && dbg_gnt));

    // A waiting requester may withdraw, but must not change its fields.
    a_cpu_stable: assert property (@(posedge clk) disable iff (!reset)
        (cpu_req && !cpu_gnt) |=> (!cpu_req ||
        ($stable(cpu_we) && $stable(cpu_addr) && $stable(cpu_wdata))));

    a_dbg_stable: assert property (@(posedge clk) disable iff (!reset)
        (dbg_req && !dbg_gnt) |=> (!dbg_req ||
        ($stable(dbg_we) && $stable(dbg_addr) && $stable(dbg_wdata))));
`endif

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// Directed bench for neander_mem_arbiter with a behavioural sync-read memory.
module tb_neander_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
    logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_data_in;
    logic [7:0] mem_data_out = 8'h00;
    logic [7:0] mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    neander_mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Single-port memory: write-first is not needed, read returns old data.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    typedef struct {
        logic       creq, cwe;
        logic [7:0] caddr, cwd;
        logic       dreq, dwe;
        logic [7:0] daddr, dwd;
        logic       lock;
        logic       e_cg, e_dg, e_we;
        logic [7:0] e_addr, e_din;
        logic       e_cv;
        logic [7:0] e_cd;
        logic       e_dv;
        logic [7:0] e_dd;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                         input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd,
                         input logic lk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        dbg_lock = lk;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit exp_dbg [17];
        bit dreq_t  [17];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5; mem[8'h05] = 8'h11; mem[8'h06] = 8'h22;
        mem[8'h30] = 8'hC3; mem[8'h40] = 8'hD4; mem[8'h50] = 8'h5A;

        //          creq cwe caddr  cwd    dreq dwe daddr  dwd    lk | cg dg we addr   din    cv cd     dv dd
        vecs[0]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00};
        vecs[1]  = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00};
        vecs[2]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h10, 8'h00, 1, 8'hA5, 0, 8'h00};
        vecs[3]  = '{1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h05, 8'h00, 0, 8'hA5, 0, 8'h00};
        vecs[4]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h06, 8'h00, 0,  0, 1, 0, 8'h06, 8'h00, 1, 8'h11, 0, 8'h00};
        vecs[5]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h06, 8'h00, 0, 8'h11, 1, 8'h22};
        vecs[6]  = '{1, 0, 8'h50, 8'h00, 1, 1, 8'h20, 8'h3C, 1,  0, 1, 1, 8'h20, 8'h3C, 0, 8'h11, 0, 8'h22};
        vecs[7]  = '{1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'h20, 8'h00, 0, 8'h11, 0, 8'h22};
        vecs[8]  = '{1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h50, 8'h00, 0, 8'h11, 0, 8'h22};
        vecs[9]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h50, 8'h00, 1, 8'h5A, 0, 8'h22};
        vecs[10] = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'h50, 8'h00, 0, 8'h5A, 0, 8'h22};
        vecs[11] = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h10, 8'h00, 0, 8'h5A, 0, 8'h22};
        vecs[12] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h10, 8'h00, 1, 8'hA5, 0, 8'h22};
        vecs[13] = '{1, 1, 8'h60, 8'h77, 0, 0, 8'h00, 8'h00, 0,  1, 0, 1, 8'h60, 8'h77, 0, 8'hA5, 0, 8'h22};
        vecs[14] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00, 0,  0, 1, 0, 8'h60, 8'h00, 0, 8'hA5, 0, 8'h22};
        vecs[15] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h60, 8'h00, 0, 8'hA5, 1, 8'h77};

        // Reset held while inputs toggle: every output stays quiet.
        reset = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            #1;
            check($sformatf("reset_quiet%0d", i),
                  {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we, mem_addr, mem_data_in,
                   cpu_rdata, dbg_rdata}, '0);
        end
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed single-cycle vectors.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd, vecs[i].lock);
            #1;
            check($sformatf("vec%0d", i),
                  {cpu_gnt, dbg_gnt, mem_we, mem_addr, mem_data_in,
                   cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata},
                  {vecs[i].e_cg, vecs[i].e_dg, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_din,
                   vecs[i].e_cv, vecs[i].e_cd, vecs[i].e_dv, vecs[i].e_dd});
        end

        // Fairness: both ports read continuously, then CPU alone, then both again.
        for (int i = 0; i < 17; i++) begin
            dreq_t[i]  = (i < 10) || (i == 16);
            exp_dbg[i] = (i >= 4 && i < 8) || (i == 16);
        end
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(1, 0, 8'h30, 8'h00, dreq_t[i], 0, 8'h40, 8'h00, 0);
            #1;
            check($sformatf("burst_gnt%0d", i), {cpu_gnt, dbg_gnt}, {~exp_dbg[i], exp_dbg[i]});
            if (i == 0)
                check("burst_rv0", {cpu_rvalid, dbg_rvalid}, 2'b00);
            else if (exp_dbg[i-1])
                check($sformatf("burst_rv%0d", i), {cpu_rvalid, dbg_rvalid, dbg_rdata},
                      {1'b0, 1'b1, 8'hD4});
            else
                check($sformatf("burst_rv%0d", i), {cpu_rvalid, dbg_rvalid, cpu_rdata},
                      {1'b1, 1'b0, 8'hC3});
        end
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        #1;
        check("burst_tail", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, dbg_rdata},
              {1'b0, 1'b0, 1'b0, 1'b1, 8'hD4});

        // Reset right after a granted debug read drops the response.
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h06, 8'h00, 0);
        #1;
        check("rst_dbg_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        #1;
        check("rst_dbg_rvalid", {cpu_rvalid, dbg_rvalid, dbg_rdata}, 10'h000);
        @(negedge clk);
        #1;
        check("rst_hold_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        // Owner back to CPU with an empty burst count: four CPU grants, then DBG.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 0);
            #1;
            check($sformatf("post_rst_gnt%0d", i), {cpu_gnt, dbg_gnt},
                  (i < 4) ? 2'b10 : 2'b01);
            if (i == 0) check("post_rst_rv", {cpu_rvalid, dbg_rvalid}, 2'b00);
        end
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
